// File: rtl/ov7670_stream_gen_if.sv
// Camera-side pixel bus of the OV7670 stream source.
// master = the generator, slave = the consumer (capture block).
interface ov7670_stream_gen_if;
   logic       enable;
   logic [1:0] pattern_sel;
   logic [7:0] solid_luma;
   logic       vsync;
   logic       href;
   logic [7:0] dout;
   logic       frame_done;
   logic       busy;

   modport master (
      input  enable,
      input  pattern_sel,
      input  solid_luma,
      output vsync,
      output href,
      output dout,
      output frame_done,
      output busy
   );

   modport slave (
      output enable,
      output pattern_sel,
      output solid_luma,
      input  vsync,
      input  href,
      input  dout,
      input  frame_done,
      input  busy
   );
endinterface

// File: rtl/ov7670_stream_gen.sv
// Synthetic OV7670 sensor: vsync/href/data on PCLK with test patterns.
// Outputs are registered from the next-cycle view of state and counters.
module ov7670_stream_gen #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int BPP         = 2,
   parameter int HBLANK_CYC  = 288,
   parameter int VSYNC_LINES = 3,
   parameter int VBP_LINES   = 17,
   parameter int VFP_LINES   = 10,
   parameter int BAR_W       = 80
) (
   input  logic                 clk,
   input  logic                 rst,
   ov7670_stream_gen_if.master  bus
);

   localparam int LINE_CYC = H_ACTIVE * BPP + HBLANK_CYC;
   localparam int CW       = 16;

   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t H_LAST   = cnt_t'(LINE_CYC - 1);
   localparam cnt_t H_ACT_B  = cnt_t'(H_ACTIVE * BPP);
   localparam cnt_t VS_LAST  = cnt_t'(VSYNC_LINES - 1);
   localparam cnt_t VBP_LAST = cnt_t'(VBP_LINES - 1);
   localparam cnt_t ACT_LAST = cnt_t'(V_ACTIVE - 1);
   localparam cnt_t VFP_LAST = cnt_t'(VFP_LINES - 1);
   localparam cnt_t PH_LAST  = cnt_t'(BPP - 1);
   localparam cnt_t BAR_LAST = cnt_t'(BAR_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_VS,
      S_VBP,
      S_ACT,
      S_VFP
   } state_t;

   state_t     r_state;
   cnt_t       r_h;
   cnt_t       r_l;
   cnt_t       r_px;
   cnt_t       r_ph;
   cnt_t       r_bcnt;
   logic [2:0] r_bidx;
   logic [1:0] r_pat;
   logic [7:0] r_solid;
   logic       r_vsync;
   logic       r_href;
   logic [7:0] r_dout;
   logic       r_done;
   logic       r_busy;

   state_t     w_state;
   cnt_t       w_h;
   cnt_t       w_l;
   cnt_t       w_px;
   cnt_t       w_ph;
   cnt_t       w_bcnt;
   logic [2:0] w_bidx;
   logic [1:0] w_pat;
   logic [7:0] w_solid;
   logic       w_start;
   logic       w_line_end;
   logic [7:0] w_luma;
   logic       w_vsync;
   logic       w_href;
   logic [7:0] w_dout;
   logic       w_done;
   logic       w_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_h        = r_h;
      w_l        = r_l;
      w_pat      = r_pat;
      w_solid    = r_solid;
      w_start    = 1'b0;
      w_line_end = (r_h == H_LAST);

      if (r_state == S_IDLE) begin
         w_start = bus.enable;
      end else if (w_line_end) begin
         w_h = '0;
         w_l = r_l + cnt_t'(1);
         unique case (r_state)
            S_VS: begin
               if (r_l == VS_LAST) begin
                  w_state = S_VBP;
                  w_l     = '0;
               end
            end
            S_VBP: begin
               if (r_l == VBP_LAST) begin
                  w_state = S_ACT;
                  w_l     = '0;
               end
            end
            S_ACT: begin
               if (r_l == ACT_LAST) begin
                  w_state = S_VFP;
                  w_l     = '0;
               end
            end
            S_VFP: begin
               if (r_l == VFP_LAST) begin
                  w_l = '0;
                  if (bus.enable) begin
                     w_start = 1'b1;
                  end else begin
                     w_state = S_IDLE;
                  end
               end
            end
            default: begin
               w_state = S_IDLE;
               w_l     = '0;
            end
         endcase
      end else begin
         w_h = r_h + cnt_t'(1);
      end

      // Frame start: pattern inputs are frozen for the whole frame
      if (w_start) begin
         w_state = S_VS;
         w_h     = '0;
         w_l     = '0;
         w_pat   = bus.pattern_sel;
         w_solid = bus.solid_luma;
      end
   end

   always_comb begin
      w_px   = r_px;
      w_ph   = r_ph;
      w_bcnt = r_bcnt;
      w_bidx = r_bidx;
      unique case (1'b1)
         (w_h == '0): begin
            w_px   = '0;
            w_ph   = '0;
            w_bcnt = '0;
            w_bidx = '0;
         end
         (w_h != '0 && r_ph == PH_LAST): begin
            w_ph = '0;
            w_px = r_px + cnt_t'(1);
            if (r_bcnt == BAR_LAST) begin
               w_bcnt = '0;
               if (r_bidx != 3'd7) begin
                  w_bidx = r_bidx + 3'd1;
               end
            end else begin
               w_bcnt = r_bcnt + cnt_t'(1);
            end
         end
         default: begin
            w_ph = r_ph + cnt_t'(1);
         end
      endcase
   end

   always_comb begin
      w_luma = 8'h00;
      unique case (w_pat)
         2'd0:    w_luma = w_px[9:2];
         2'd1:    w_luma = {w_bidx, 5'b0};
         2'd2:    w_luma = (w_px[5] ^ w_l[5]) ? 8'hFF : 8'h00;
         default: w_luma = w_solid;
      endcase
   end

   always_comb begin
      w_vsync = (w_state == S_VS);
      w_href  = (w_state == S_ACT) && (w_h < H_ACT_B);
      w_busy  = (w_state != S_IDLE);
      w_done  = (w_state == S_VFP) && (w_h == H_LAST) &&
                (w_l == VFP_LAST);
      w_dout  = 8'h00;
      if (w_href) begin
         w_dout = (w_ph == '0) ? w_luma : 8'h80;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_h     <= '0;
         r_l     <= '0;
         r_px    <= '0;
         r_ph    <= '0;
         r_bcnt  <= '0;
         r_bidx  <= '0;
         r_pat   <= '0;
         r_solid <= '0;
         r_vsync <= 1'b0;
         r_href  <= 1'b0;
         r_dout  <= 8'h00;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_h     <= w_h;
         r_l     <= w_l;
         r_px    <= w_px;
         r_ph    <= w_ph;
         r_bcnt  <= w_bcnt;
         r_bidx  <= w_bidx;
         r_pat   <= w_pat;
         r_solid <= w_solid;
         r_vsync <= w_vsync;
         r_href  <= w_href;
         r_dout  <= w_dout;
         r_done  <= w_done;
         r_busy  <= w_busy;
      end
   end

   assign bus.vsync      = r_vsync;
   assign bus.href       = r_href;
   assign bus.dout       = r_dout;
   assign bus.frame_done = r_done;
   assign bus.busy       = r_busy;

endmodule
